// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the ID instruction, reads the register file and loads the ID/EX register.
// Latency: one cycle from ID to the E outputs; StallD is combinational.
// Backpressure: a load-use hazard raises StallD and loads a bubble while the ID instruction is held upstream.
module decode_stage #(
    parameter logic [31:0] RESET_PC              = 32'h0000_0000,
    parameter bit          ZERO_REGFILE_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        ValidD,
    input  logic        FlushE,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic        StallD,
    output logic        ValidE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic        JumpE,
    output logic        ALUSrcAE,
    output logic        ALUSrcBE,
    output logic [1:0]  ResultSrcE,
    output logic [3:0]  ALUControlE,
    output logic [2:0]  Funct3E,
    output logic        IllegalE
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [1:0]  result_src;
        logic [3:0]  alu_ctrl;
        logic [2:0]  funct3;
        logic        illegal;
    } idex_t;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'b000:  alu_sel = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode   = InstrD[6:0];
    assign rd       = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign funct7b5 = InstrD[30];

    assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_u = {InstrD[31:12], 12'b0};
    assign imm_j = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    logic [31:0] rf [32];
    logic [31:0] rd1, rd2;

    generate
        if (ZERO_REGFILE_ON_RESET) begin : g_rf_rst
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < 32; i++) rf[i] <= '0;
                end else if (RegWriteW && RdW != 5'd0) begin
                    rf[RdW] <= ResultW;
                end
            end
        end else begin : g_rf_norst
            always_ff @(posedge clk) begin
                if (RegWriteW && RdW != 5'd0) rf[RdW] <= ResultW;
            end
        end
    endgenerate

    // x0 is hard-wired; a same-cycle writeback to the read index bypasses the array.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) rd1 = (RegWriteW && RdW == rs1) ? ResultW : rf[rs1];
        if (rs2 != 5'd0) rd2 = (RegWriteW && RdW == rs2) ? ResultW : rf[rs2];
    end

    logic        reg_write, mem_write, branch, jump, src_a, src_b, illegal;
    logic        use_rs1, use_rs2;
    logic [1:0]  result_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] imm;

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        src_a      = 1'b0;
        src_b      = 1'b0;
        illegal    = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        result_src = RES_ALU;
        alu_ctrl   = ALU_ADD;
        imm        = '0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_ctrl  = alu_sel(funct3, funct7b5, 1'b1);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OP_I: begin
                reg_write = 1'b1;
                src_b     = 1'b1;
                alu_ctrl  = alu_sel(funct3, funct7b5, 1'b0);
                imm       = imm_i;
                use_rs1   = 1'b1;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                src_b      = 1'b1;
                result_src = RES_MEM;
                imm        = imm_i;
                use_rs1    = 1'b1;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                src_b     = 1'b1;
                imm       = imm_s;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OP_BR: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
                imm      = imm_b;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OP_JAL: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_PC4;
                imm        = imm_j;
            end
            OP_JALR: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                src_b      = 1'b1;
                result_src = RES_PC4;
                imm        = imm_i;
                use_rs1    = 1'b1;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                src_b     = 1'b1;
                alu_ctrl  = ALU_PASSB;
                imm       = imm_u;
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                src_a     = 1'b1;
                src_b     = 1'b1;
                imm       = imm_u;
            end
            default: illegal = 1'b1;
        endcase
    end

    idex_t idex_q, dec, bubble;

    always_comb begin
        bubble          = '0;
        bubble.pc       = RESET_PC;
        bubble.pc_plus4 = RESET_PC + 32'd4;
    end

    always_comb begin
        dec            = '0;
        dec.valid      = 1'b1;
        dec.rd1        = rd1;
        dec.rd2        = rd2;
        dec.imm        = imm;
        dec.pc         = PCD;
        dec.pc_plus4   = PCPlus4D;
        dec.rs1        = rs1;
        dec.rs2        = rs2;
        dec.rd         = rd;
        dec.reg_write  = reg_write;
        dec.mem_write  = mem_write;
        dec.branch     = branch;
        dec.jump       = jump;
        dec.alu_src_a  = src_a;
        dec.alu_src_b  = src_b;
        dec.result_src = result_src;
        dec.alu_ctrl   = alu_ctrl;
        dec.funct3     = funct3;
        dec.illegal    = illegal;
    end

    // Only register operands the instruction actually reads can create a load-use dependency.
    logic load_in_e;
    assign load_in_e = ValidE && (ResultSrcE == RES_MEM) && (RdE != 5'd0);
    assign StallD    = !reset && ValidD && load_in_e &&
                       ((use_rs1 && rs1 == RdE) || (use_rs2 && rs2 == RdE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= bubble;
        end else if (FlushE || StallD || !ValidD) begin
            idex_q <= bubble;
        end else begin
            idex_q <= dec;
        end
    end

    assign ValidE      = idex_q.valid;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;
    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign BranchE     = idex_q.branch;
    assign JumpE       = idex_q.jump;
    assign ALUSrcAE    = idex_q.alu_src_a;
    assign ALUSrcBE    = idex_q.alu_src_b;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_ctrl;
    assign Funct3E     = idex_q.funct3;
    assign IllegalE    = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected E-stage contents are queued as each ID instruction is
// driven and popped one cycle later when the ID/EX register presents them.
module tb_decode_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        ValidD, FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic        StallD, ValidE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE, ALUSrcBE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic        IllegalE;

    decode_stage #(.RESET_PC(RPC), .ZERO_REGFILE_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallD(StallD), .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .Funct3E(Funct3E), .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

    // {RegWrite, MemWrite, Branch, Jump, ALUSrcA, ALUSrcB, ResultSrc[1:0], ALUControl[3:0], Illegal}
    logic [12:0] ctrl_e;
    assign ctrl_e = {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE, ALUSrcBE,
                     ResultSrcE, ALUControlE, IllegalE};

    typedef struct {
        logic        valid;
        logic [12:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic        ci, c1, c2;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [12:0] ctrl;
        logic [31:0] imm;
        logic        ci, u1, u2;
    } row_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] rf_m [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        InstrD = '0; PCD = '0; PCPlus4D = '0; ValidD = 1'b0; FlushE = 1'b0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] p);
        InstrD = ins; PCD = p; PCPlus4D = p + 32'd4; ValidD = 1'b1;
    endtask

    function automatic logic [31:0] rd_m(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWriteW && RdW == a) return ResultW;
        return rf_m[a];
    endfunction

    function automatic exp_t mk(input logic v, input logic [12:0] c, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [2:0] f3, input logic [31:0] pc,
                                input logic ci, input logic c1, input logic c2);
        exp_t x;
        x.valid = v; x.ctrl = c; x.imm = imm; x.rd = rd; x.rd1 = r1; x.rd2 = r2;
        x.f3 = f3; x.pc = pc; x.ci = ci; x.c1 = c1; x.c2 = c2;
        return x;
    endfunction

    task automatic wb_commit;
        if (RegWriteW && RdW != 5'd0) rf_m[RdW] = ResultW;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle();
        InstrD = 32'h00028333; ValidD = 1'b1;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        #3;
        n_tests++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ValidE); end
        n_tests++; if (ctrl_e !== 13'd0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_e); end
        n_tests++; if (PCE !== RPC || PCPlus4E !== RPC + 32'd4) begin n_fail++; $display("FAIL reset_pc got=%h/%h exp=%h/%h", PCE, PCPlus4E, RPC, RPC + 32'd4); end
        n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", StallD); end
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_addi;
        drive(32'h00500093, 32'h100);
        sb.push_back(mk(1, 13'b1_0_0_0_0_1_00_0000_0, 32'd5, 5'd1, 32'd0, 0, 3'b000, 32'h100, 1, 1, 0));
        tick();
        e = sb.pop_front();
        n_tests++; if (ValidE !== e.valid) begin n_fail++; $display("FAIL addi_valid got=%b exp=%b", ValidE, e.valid); end
        n_tests++; if (ctrl_e !== e.ctrl) begin n_fail++; $display("FAIL addi_ctrl got=%b exp=%b", ctrl_e, e.ctrl); end
        n_tests++; if (ImmExtE !== e.imm) begin n_fail++; $display("FAIL addi_imm got=%h exp=%h", ImmExtE, e.imm); end
        n_tests++; if (RdE !== e.rd) begin n_fail++; $display("FAIL addi_rd got=%0d exp=%0d", RdE, e.rd); end
        n_tests++; if (RD1E !== e.rd1) begin n_fail++; $display("FAIL addi_rd1 got=%h exp=%h", RD1E, e.rd1); end
        n_tests++; if (PCE !== e.pc || PCPlus4E !== e.pc + 32'd4) begin n_fail++; $display("FAIL addi_pc got=%h/%h exp=%h", PCE, PCPlus4E, e.pc); end
        idle();
    endtask

    task automatic test_write_through;
        drive(32'h002101B3, 32'h104);
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'hDEADBEEF;
        sb.push_back(mk(1, 13'b1_0_0_0_0_0_00_0000_0, 0, 5'd3, rd_m(5'd2), rd_m(5'd2), 3'b000, 32'h104, 0, 1, 1));
        tick();
        wb_commit();
        RegWriteW = 1'b0;
        drive(32'h40210233, 32'h108);
        sb.push_back(mk(1, 13'b1_0_0_0_0_0_00_0001_0, 0, 5'd4, rd_m(5'd2), rd_m(5'd2), 3'b000, 32'h108, 0, 1, 1));
        for (int k = 0; k < 2; k++) begin
            if (k == 1) tick();
            e = sb.pop_front();
            n_tests++; if (RD1E !== e.rd1 || RD2E !== e.rd2) begin n_fail++; $display("FAIL wt_operands[%0d] got=%h/%h exp=%h/%h", k, RD1E, RD2E, e.rd1, e.rd2); end
            n_tests++; if (ctrl_e !== e.ctrl || RdE !== e.rd) begin n_fail++; $display("FAIL wt_ctrl[%0d] got=%b rd=%0d exp=%b rd=%0d", k, ctrl_e, RdE, e.ctrl, e.rd); end
        end
        idle();
    endtask

    task automatic test_load_use;
        logic [12:0] lw_ctrl;
        lw_ctrl = 13'b1_0_0_0_0_1_01_0000_0;
        drive(32'h0000A283, 32'h200);
        sb.push_back(mk(1, lw_ctrl, 0, 5'd5, 0, 0, 3'b010, 32'h200, 1, 0, 0));
        tick();
        e = sb.pop_front();
        n_tests++; if (ValidE !== 1'b1 || ctrl_e !== e.ctrl || Funct3E !== e.f3 || RdE !== e.rd) begin n_fail++; $display("FAIL lu_load got=%b %b f3=%b rd=%0d exp=1 %b f3=%b rd=%0d", ValidE, ctrl_e, Funct3E, RdE, e.ctrl, e.f3, e.rd); end
        drive(32'h00028333, 32'h204);
        #1;
        n_tests++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", StallD); end
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h0000_0055;
        sb.push_back(mk(0, 13'd0, 0, 0, 0, 0, 0, RPC, 0, 0, 0));
        tick();
        wb_commit();
        RegWriteW = 1'b0;
        e = sb.pop_front();
        n_tests++; if (ValidE !== e.valid || ctrl_e !== e.ctrl) begin n_fail++; $display("FAIL lu_bubble got=%b %b exp=%b %b", ValidE, ctrl_e, e.valid, e.ctrl); end
        n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL lu_release got=%b exp=0", StallD); end
        sb.push_back(mk(1, 13'b1_0_0_0_0_0_00_0000_0, 0, 5'd6, rd_m(5'd5), 0, 3'b000, 32'h204, 0, 1, 1));
        tick();
        e = sb.pop_front();
        n_tests++; if (ValidE !== 1'b1 || RdE !== e.rd || Rs1E !== 5'd5 || RD1E !== e.rd1) begin n_fail++; $display("FAIL lu_issue got=%b rd=%0d rs1=%0d rd1=%h exp=1 rd=%0d rs1=5 rd1=%h", ValidE, RdE, Rs1E, RD1E, e.rd, e.rd1); end
        // lui whose upper-immediate bits alias rs1=x5 must not stall
        drive(32'h0000A283, 32'h208);
        tick();
        drive(32'h000283B7, 32'h20C);
        #1;
        n_tests++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL lu_lui_nostall got=%b exp=0", StallD); end
        sb.push_back(mk(1, 13'b1_0_0_0_0_1_00_1010_0, 32'h00028000, 5'd7, 0, 0, 0, 32'h20C, 1, 0, 0));
        tick();
        e = sb.pop_front();
        n_tests++; if (ValidE !== 1'b1 || ctrl_e !== e.ctrl || ImmExtE !== e.imm) begin n_fail++; $display("FAIL lu_lui got=%b %b %h exp=1 %b %h", ValidE, ctrl_e, ImmExtE, e.ctrl, e.imm); end
        // stall on rs2 of a store, together with a flush
        drive(32'h0000A283, 32'h210);
        tick();
        drive(32'h00502023, 32'h214);
        FlushE = 1'b1;
        #1;
        n_tests++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL lu_flush_stall got=%b exp=1", StallD); end
        sb.push_back(mk(0, 13'd0, 0, 0, 0, 0, 0, RPC, 0, 0, 0));
        tick();
        FlushE = 1'b0;
        e = sb.pop_front();
        n_tests++; if (ValidE !== e.valid || ctrl_e !== e.ctrl) begin n_fail++; $display("FAIL lu_flush_bubble got=%b %b exp=0 0", ValidE, ctrl_e); end
        idle();
    endtask

    task automatic test_branch;
        drive(32'hFE000CE3, 32'h300);
        sb.push_back(mk(1, 13'b0_0_1_0_0_0_00_0001_0, 32'hFFFFFFF8, 0, 0, 0, 3'b000, 32'h300, 1, 0, 0));
        tick();
        e = sb.pop_front();
        n_tests++; if (ctrl_e !== e.ctrl) begin n_fail++; $display("FAIL br_ctrl got=%b exp=%b", ctrl_e, e.ctrl); end
        n_tests++; if (ImmExtE !== e.imm || Funct3E !== e.f3) begin n_fail++; $display("FAIL br_imm got=%h f3=%b exp=%h f3=%b", ImmExtE, Funct3E, e.imm, e.f3); end
        idle();
    endtask

    task automatic test_flush;
        drive(32'h010000EF, 32'h400);
        FlushE = 1'b1;
        sb.push_back(mk(0, 13'd0, 0, 0, 0, 0, 0, RPC, 0, 0, 0));
        tick();
        e = sb.pop_front();
        n_tests++; if (ValidE !== e.valid || JumpE !== 1'b0 || RegWriteE !== 1'b0) begin n_fail++; $display("FAIL fl_bubble got=v%b j%b rw%b exp=0 0 0", ValidE, JumpE, RegWriteE); end
        n_tests++; if (PCE !== e.pc) begin n_fail++; $display("FAIL fl_pc got=%h exp=%h", PCE, e.pc); end
        FlushE = 1'b0;
        sb.push_back(mk(1, 13'b1_0_0_1_0_0_10_0000_0, 32'd16, 5'd1, 0, 0, 0, 32'h400, 1, 0, 0));
        tick();
        e = sb.pop_front();
        n_tests++; if (ValidE !== 1'b1 || ctrl_e !== e.ctrl || ImmExtE !== e.imm || PCE !== e.pc) begin n_fail++; $display("FAIL fl_jal got=%b %b %h %h exp=1 %b %h %h", ValidE, ctrl_e, ImmExtE, PCE, e.ctrl, e.imm, e.pc); end
        idle();
    endtask

    task automatic test_x0_illegal;
        drive(32'h00000413, 32'h500);
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h0000_1234;
        sb.push_back(mk(1, 13'b1_0_0_0_0_1_00_0000_0, 0, 5'd8, rd_m(5'd0), 0, 0, 32'h500, 1, 1, 0));
        tick();
        wb_commit();
        RegWriteW = 1'b0;
        e = sb.pop_front();
        n_tests++; if (RD1E !== e.rd1) begin n_fail++; $display("FAIL x0_same_cycle got=%h exp=%h", RD1E, e.rd1); end
        drive(32'h00000413, 32'h504);
        sb.push_back(mk(1, 13'b1_0_0_0_0_1_00_0000_0, 0, 5'd8, rd_m(5'd0), 0, 0, 32'h504, 1, 1, 0));
        tick();
        e = sb.pop_front();
        n_tests++; if (RD1E !== e.rd1) begin n_fail++; $display("FAIL x0_read got=%h exp=%h", RD1E, e.rd1); end
        drive(32'h0000007F, 32'h508);
        sb.push_back(mk(1, 13'b0_0_0_0_0_0_00_0000_1, 0, 0, 0, 0, 0, 32'h508, 0, 0, 0));
        tick();
        e = sb.pop_front();
        n_tests++; if (IllegalE !== 1'b1 || RegWriteE !== 1'b0 || ctrl_e !== e.ctrl || ValidE !== e.valid) begin n_fail++; $display("FAIL illegal got=ill%b rw%b %b v%b exp=1 0 %b 1", IllegalE, RegWriteE, ctrl_e, ValidE, e.ctrl); end
        idle();
    endtask

    task automatic test_back_to_back;
        row_t rows[6];
        rows[0] = '{32'h00252623, 13'b0_1_0_0_0_1_00_0000_0, 32'd12,        1, 1, 1};
        rows[1] = '{32'h40355593, 13'b1_0_0_0_0_1_00_0111_0, 32'h00000403,  1, 1, 0};
        rows[2] = '{32'hC0000613, 13'b1_0_0_0_0_1_00_0000_0, 32'hFFFFFC00,  1, 1, 0};
        rows[3] = '{32'h12345697, 13'b1_0_0_0_1_1_00_0000_0, 32'h12345000,  1, 0, 0};
        rows[4] = '{32'h004500E7, 13'b1_0_0_1_0_1_10_0000_0, 32'd4,         1, 1, 0};
        rows[5] = '{32'h00253733, 13'b1_0_0_0_0_0_00_1001_0, 32'd0,         0, 1, 1};
        RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'h0000_1000;
        tick();
        wb_commit();
        idle();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ins;
            ins = rows[i].ins;
            drive(ins, 32'h600 + 32'(i * 4));
            sb.push_back(mk(1, rows[i].ctrl, rows[i].imm, ins[11:7], rd_m(ins[19:15]), rd_m(ins[24:20]),
                            ins[14:12], 32'h600 + 32'(i * 4), rows[i].ci, rows[i].u1, rows[i].u2));
            tick();
            e = sb.pop_front();
            n_tests++; if (ValidE !== 1'b1 || ctrl_e !== e.ctrl || RdE !== e.rd || Funct3E !== e.f3 || PCE !== e.pc) begin n_fail++; $display("FAIL b2b_ctrl[%0d] got=%b %b rd=%0d f3=%b pc=%h exp=1 %b rd=%0d f3=%b pc=%h", i, ValidE, ctrl_e, RdE, Funct3E, PCE, e.ctrl, e.rd, e.f3, e.pc); end
            if (e.ci) begin
                n_tests++; if (ImmExtE !== e.imm) begin n_fail++; $display("FAIL b2b_imm[%0d] got=%h exp=%h", i, ImmExtE, e.imm); end
            end
            if (e.c1) begin
                n_tests++; if (RD1E !== e.rd1) begin n_fail++; $display("FAIL b2b_rd1[%0d] got=%h exp=%h", i, RD1E, e.rd1); end
            end
            if (e.c2) begin
                n_tests++; if (RD2E !== e.rd2) begin n_fail++; $display("FAIL b2b_rd2[%0d] got=%h exp=%h", i, RD2E, e.rd2); end
            end
        end
        idle();
    endtask

    task automatic test_reset_midop;
        drive(32'h00500093, 32'h700);
        tick();
        n_tests++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%b exp=1", ValidE); end
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (ValidE !== 1'b0 || ctrl_e !== 13'd0 || PCPlus4E !== RPC + 32'd4) begin n_fail++; $display("FAIL mid_reset got=%b %b %h exp=0 0 %h", ValidE, ctrl_e, PCPlus4E, RPC + 32'd4); end
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        tick();
        reset = 1'b0;
        drive(32'h002101B3, 32'h704);
        sb.push_back(mk(1, 13'b1_0_0_0_0_0_00_0000_0, 0, 5'd3, rd_m(5'd2), rd_m(5'd2), 0, 32'h704, 0, 1, 1));
        tick();
        e = sb.pop_front();
        n_tests++; if (RD1E !== e.rd1 || RD2E !== e.rd2) begin n_fail++; $display("FAIL mid_rf_clear got=%h/%h exp=%h/%h", RD1E, RD2E, e.rd1, e.rd2); end
        idle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_write_through();
        test_load_use();
        test_branch();
        test_flush();
        test_x0_illegal();
        test_back_to_back();
        test_reset_midop();
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
